// File: rtl/pend_sched_pkg.sv
// Shared constants for the pending-event scheduler: default line count and
// coalesce counter width, plus the index-width helper.
package pend_sched_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int PEND_SCHED_CW = 8;

  // Index width that stays at least 1 bit even for degenerate widths.
  function automatic int idx_width(input int lines);
    return (lines <= 2) ? 1 : $clog2(lines);
  endfunction

endpackage

// File: rtl/pend_sched_binenc.sv
// Priority binary encoder: reports the highest set bit of req, MSB-first.
module pend_sched_binenc #(
  parameter int n  = 8,
  parameter int IW = 3
) (
  input  logic [n-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    for (int i = 0; i < n; i++) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/pend_sched.sv
// Event-pending scheduler feeding a registered valid/ready index slot.
// Define PEND_SCHED_RR_EN for round-robin selection; otherwise strict MSB-first priority.
module pend_sched
  import pend_sched_pkg::*;
#(
  parameter int  n  = DEFAULT_WIDTH,
  parameter int  CW = PEND_SCHED_CW,
  localparam int IW = idx_width(n)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [n-1:0]  set_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [n-1:0]  pending,
  output logic [CW-1:0] coal_cnt
);

  localparam int PW = $clog2(n + 1);
  localparam int SW = ((CW > PW) ? CW : PW) + 1;

  logic [n-1:0]  pending_reg;
  logic          out_valid_reg;
  logic [IW-1:0] out_idx_reg;
  logic [CW-1:0] coal_cnt_reg;

  logic [IW-1:0] top_idx;
  logic          top_any;
  logic [IW-1:0] sel;
  logic          slot_free;
  logic          load;
  logic [n-1:0]  load_onehot;
  logic [n-1:0]  pending_next;
  logic [n-1:0]  coal_bits;
  logic [PW-1:0] coal_pop;
  logic [SW-1:0] coal_sum;
  logic [CW-1:0] coal_next;

  pend_sched_binenc #(.n(n), .IW(IW)) u_enc_all (
    .req (pending_reg),
    .idx (top_idx),
    .any (top_any)
  );

`ifdef PEND_SCHED_RR_EN
  logic [IW-1:0] ptr_reg;
  logic [n-1:0]  rr_mask;
  logic [IW-1:0] rr_idx;
  logic          rr_any;

  // Lines strictly below the last issued index are eligible first.
  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_rr_mask
      assign rr_mask[gi] = pending_reg[gi] && (IW'(gi) < ptr_reg);
    end
  endgenerate

  pend_sched_binenc #(.n(n), .IW(IW)) u_enc_rr (
    .req (rr_mask),
    .idx (rr_idx),
    .any (rr_any)
  );

  assign sel = rr_any ? rr_idx : top_idx;
`else
  assign sel = top_idx;
`endif

  assign slot_free = !out_valid_reg || out_ready;
  assign load      = slot_free && top_any;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_onehot
      assign load_onehot[gi] = load && (sel == IW'(gi));
    end
  endgenerate

  // A same-edge set on the line being loaded wins, so it re-pends.
  assign pending_next = (pending_reg & ~load_onehot) | set_in;
  assign coal_bits    = set_in & pending_reg;

  always_comb begin
    coal_pop = '0;
    for (int i = 0; i < n; i++) begin
      coal_pop = coal_pop + PW'(coal_bits[i]);
    end
  end

  assign coal_sum  = SW'(coal_cnt_reg) + SW'(coal_pop);
  assign coal_next = (|coal_sum[SW-1:CW]) ? {CW{1'b1}} : coal_sum[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      coal_cnt_reg  <= '0;
`ifdef PEND_SCHED_RR_EN
      ptr_reg       <= IW'(n - 1);
`endif
    end else if (flush) begin
      pending_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      coal_cnt_reg <= coal_next;
      if (slot_free) begin
        out_valid_reg <= load;
      end
      if (load) begin
        out_idx_reg <= sel;
`ifdef PEND_SCHED_RR_EN
        ptr_reg     <= sel;
`endif
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign pending   = pending_reg;
  assign coal_cnt  = coal_cnt_reg;

endmodule

// File: tb/tb_pend_sched.sv
// Scoreboard bench for pend_sched (n=8, CW=4): reference model pushes expectations,
// a negedge monitor pops and compares.
module tb_pend_sched;

  localparam int N   = 8;
  localparam int CWB = 4;
  localparam int SAT = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [N-1:0] set_in = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [2:0]   out_idx;
  logic [N-1:0] pending;
  logic [CWB-1:0] coal_cnt;

  pend_sched #(.n(N), .CW(CWB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .set_in    (set_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .coal_cnt  (coal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [2:0]   idx;
    logic [N-1:0] pend;
    logic [3:0]   coal;
  } snap_t;

  int    checks = 0;
  int    errors = 0;
  snap_t snap_q[$];
  int    acc_q[$];
  int    acc_log[$];
  bit    in_reset = 1'b1;

  // Reference model state: what the DUT's registers should hold this cycle.
  bit           m_valid;
  int           m_idx;
  logic [N-1:0] m_pend;
  int           m_coal;
  int           m_ptr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int choose(input logic [N-1:0] p, input int ptr);
    int best;
    best = -1;
`ifdef PEND_SCHED_RR_EN
    for (int i = 0; i < N; i++) if (p[i] && i < ptr) best = i;
    if (best < 0) for (int i = 0; i < N; i++) if (p[i]) best = i;
`else
    for (int i = 0; i < N; i++) if (p[i]) best = i;
`endif
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_pend  = '0;
    m_coal  = 0;
    m_ptr   = N - 1;
  endtask

  task automatic apply(input logic [N-1:0] s, input bit r, input bit f);
    snap_t sn;
    bit    free;
    int    c;
    set_in    = s;
    out_ready = r;
    flush     = f;
    sn.v    = m_valid;
    sn.idx  = m_idx[2:0];
    sn.pend = m_pend;
    sn.coal = m_coal[3:0];
    snap_q.push_back(sn);
    if (f) begin
      m_pend  = '0;
      m_valid = 1'b0;
    end else begin
      free = !m_valid || r;
      if (m_valid && r) acc_q.push_back(m_idx);
      m_coal = m_coal + $countones(s & m_pend);
      if (m_coal > SAT) m_coal = SAT;
      if (free) begin
        if (m_pend != '0) begin
          c = choose(m_pend, m_ptr);
          m_valid   = 1'b1;
          m_idx     = c;
          m_pend[c] = 1'b0;
          m_ptr     = c;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = m_pend | s;
    end
    $display("cycle t=%0t set_in=%02h ready=%0d flush=%0d exp_valid=%0d exp_idx=%0d exp_pend=%02h exp_coal=%0d",
             $time, s, r, f, m_valid, m_idx, m_pend, m_coal);
  endtask

  task automatic drive(input logic [N-1:0] s, input bit r, input bit f);
    @(posedge clk);
    #1;
    apply(s, r, f);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_reset = 1'b1;
    snap_q.delete();
    acc_q.delete();
    rst_n     = 1'b0;
    set_in    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_pending", int'(pending), 0);
    check("async_rst_coal", int'(coal_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    in_reset = 1'b0;
    apply('0, 1'b0, 1'b0);
  endtask

  // Monitor: one snapshot per cycle plus every observed handshake.
  initial begin
    snap_t s;
    int    e;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (snap_q.size() > 0) begin
          s = snap_q.pop_front();
          check("out_valid", int'(out_valid), int'(s.v));
          check("pending", int'(pending), int'(s.pend));
          check("coal_cnt", int'(coal_cnt), int'(s.coal));
          if (s.v) check("out_idx", int'(out_idx), int'(s.idx));
        end
        if (out_valid && out_ready && !flush) begin
          if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept_unexpected actual=%0d required=none t=%0t", out_idx, $time);
          end else begin
            e = acc_q.pop_front();
            check("accept_idx", int'(out_idx), e);
          end
          acc_log.push_back(int'(out_idx));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    logic [N-1:0] rs;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    apply('0, 1'b0, 1'b0);

    // Priority order 5,2,0
    acc_log.delete();
    drive(8'b0010_0101, 1'b1, 1'b0);
    repeat (6) drive('0, 1'b1, 1'b0);
    sz = acc_log.size();
    check("prio_count", sz, 3);
    if (sz >= 3) begin
      check("prio_first", acc_log[0], 5);
      check("prio_second", acc_log[1], 2);
      check("prio_third", acc_log[2], 0);
    end

    // Backpressure holds index 0, then 7
    acc_log.delete();
    drive(8'h01, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h80, 1'b0, 1'b0);
    repeat (3) drive('0, 1'b0, 1'b0);
    repeat (4) drive('0, 1'b1, 1'b0);
    sz = acc_log.size();
    check("bp_count", sz, 2);
    if (sz >= 2) begin
      check("bp_first", acc_log[0], 0);
      check("bp_second", acc_log[1], 7);
    end

    // Async reset mid-run with pending lines and nonzero coalesce count
    repeat (3) drive(8'hFF, 1'b0, 1'b0);
    do_reset();
    repeat (2) drive('0, 1'b0, 1'b0);

    // Coalesce saturation
    repeat (20) drive(8'h0C, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);
    #2;
    check("coal_saturate", int'(coal_cnt), SAT);
    repeat (5) drive('0, 1'b1, 1'b0);

    // Flush overrides a same-cycle accept
    do_reset();
    drive(8'h01, 1'b0, 1'b0);
    drive(8'hF0, 1'b0, 1'b0);
    drive(8'h10, 1'b0, 1'b0);
    drive(8'h01, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0);
    #2;
    check("flush_pending", int'(pending), 0);
    check("flush_valid", int'(out_valid), 0);
    check("flush_coal", int'(coal_cnt), 1);
    drive('0, 1'b1, 1'b0);

    // Two-line contention: alternation with RR, line 7 only without
    acc_log.delete();
    repeat (10) drive(8'h81, 1'b1, 1'b0);
    repeat (4) drive('0, 1'b1, 1'b0);
    sz = acc_log.size();
    if (sz < 8) begin
      checks++;
      errors++;
      $display("FAIL rr_count actual=%0d required=8", sz);
    end else begin
      for (int i = 1; i < 8; i++) begin
`ifdef PEND_SCHED_RR_EN
        check("rr_alternate", acc_log[i] + acc_log[i-1], 7);
`else
        check("prio_always7", acc_log[i], 7);
`endif
      end
    end

    // Randomized traffic with rare flushes and a mid-run reset
    for (int k = 0; k < 600; k++) begin
      rs = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      drive(rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      if (k == 300) do_reset();
    end
    drive('0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("acc_queue_drained", acc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
